// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the multi-cycle multiply/divide unit.
// The core is the master (issues requests, consumes results); the unit is the slave.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_rs1;
   logic [XLEN-1:0] req_rs2;
   logic [4:0]      req_rd;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_result;
   logic [4:0]      rsp_rd;

   modport master (
      output req_valid, req_funct3, req_rs1, req_rs2, req_rd, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_rd
   );

   modport slave (
      input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_rd
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV M-extension unit: shift-add multiply (MUL_BITS/cycle) and
// restoring divide (1 bit/cycle) on magnitudes, with sign fix-up afterwards.
module muldiv_unit #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 4
) (
   input  logic         SYS_clk,
   input  logic         SYS_reset_n,
   input  logic         flush,
   muldiv_unit_if.slave bus,
   output logic         busy,
   output logic [1:0]   dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; valid never waits on ready, and DONE holds result/rd stable until taken.
   localparam int ITER_MUL = XLEN / MUL_BITS;
   localparam int CW       = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   MUL_LAST = CW'(ITER_MUL - 1);
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   opnd;       // multiplicand for mul, divisor for div
   logic [2*XLEN-1:0] acc;        // {hi, multiplier} for mul, quotient in low half for div
   logic [XLEN-1:0]   rem;
   logic              neg_q;
   logic              special_q;
   logic [XLEN-1:0]   spec_res_q;
   logic [XLEN-1:0]   rsp_result_q;
   logic [4:0]        rsp_rd_q;

   logic              accept;
   logic              in_div, a_sgn, b_sgn, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, spec_res;
   logic [XLEN+MUL_BITS-1:0] mul_hi_ext, mul_a_ext, mul_d_ext, mul_sum;
   logic [XLEN:0]     div_shift, div_diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rmd, fix_res;

   assign accept        = bus.req_valid && bus.req_ready;
   assign bus.req_ready = (state == S_IDLE) && !flush;
   assign bus.rsp_valid = (state == S_DONE);
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_rd    = rsp_rd_q;
   assign busy          = (state != S_IDLE);
   assign dbg_state     = state;

   // Operand decode at accept: signedness, magnitudes and the two special cases.
   always_comb begin
      in_div = bus.req_funct3[2];
      a_sgn  = 1'b0;
      b_sgn  = 1'b0;
      if (in_div) begin
         a_sgn = bus.req_rs1[XLEN-1] & ~bus.req_funct3[0];
         b_sgn = bus.req_rs2[XLEN-1] & ~bus.req_funct3[0];
      end else begin
         a_sgn = bus.req_rs1[XLEN-1] &
                 ((bus.req_funct3[1:0] == 2'b01) || (bus.req_funct3[1:0] == 2'b10));
         b_sgn = bus.req_rs2[XLEN-1] & (bus.req_funct3[1:0] == 2'b01);
      end
      a_mag    = a_sgn ? -bus.req_rs1 : bus.req_rs1;
      b_mag    = b_sgn ? -bus.req_rs2 : bus.req_rs2;
      div_zero = in_div && (bus.req_rs2 == '0);
      div_ovf  = in_div && !bus.req_funct3[0] &&
                 (bus.req_rs1 == MOST_NEG) && (bus.req_rs2 == '1);
      spec_res = '0;
      if (div_zero)
         spec_res = bus.req_funct3[1] ? bus.req_rs1 : '1;
      else if (div_ovf)
         spec_res = bus.req_funct3[1] ? '0 : bus.req_rs1;
   end

   always_comb begin
      mul_hi_ext = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]};
      mul_a_ext  = {{MUL_BITS{1'b0}}, opnd};
      mul_d_ext  = {{XLEN{1'b0}}, acc[MUL_BITS-1:0]};
      mul_sum    = mul_hi_ext + mul_a_ext * mul_d_ext;
      div_shift  = {rem, acc[XLEN-1]};
      div_diff   = div_shift - {1'b0, opnd};
   end

   always_comb begin
      prod    = neg_q ? -acc : acc;
      quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rmd     = neg_q ? -rem : rem;
      fix_res = prod[XLEN-1:0];
      if (special_q)
         fix_res = spec_res_q;
      else if (op_q[2])
         fix_res = op_q[1] ? rmd : quo;
      else if (op_q[1:0] != 2'b00)
         fix_res = prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) state <= S_IDLE;
      else              state <= state_nxt;
   end

   // Special cases still pass through FIX so their result is registered one edge
   // after accept, giving a uniform rsp path.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = (div_zero || div_ovf) ? S_FIX : S_CALC;
         S_CALC: if (cnt == '0) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: if (bus.rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         cnt          <= '0;
         op_q         <= '0;
         rd_q         <= '0;
         opnd         <= '0;
         acc          <= '0;
         rem          <= '0;
         neg_q        <= 1'b0;
         special_q    <= 1'b0;
         spec_res_q   <= '0;
         rsp_result_q <= '0;
         rsp_rd_q     <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               op_q       <= bus.req_funct3;
               rd_q       <= bus.req_rd;
               opnd       <= in_div ? b_mag : a_mag;
               acc        <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
               rem        <= '0;
               cnt        <= in_div ? DIV_LAST : MUL_LAST;
               neg_q      <= (in_div && bus.req_funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
               special_q  <= div_zero || div_ovf;
               spec_res_q <= spec_res;
            end
            S_CALC: begin
               cnt <= cnt - CW'(1);
               if (op_q[2]) begin
                  rem             <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                  acc[XLEN-1:0]   <= {acc[XLEN-2:0], ~div_diff[XLEN]};
               end else begin
                  acc <= {mul_sum, acc[XLEN-1:MUL_BITS]};
               end
            end
            S_FIX: begin
               rsp_result_q <= fix_res;
               rsp_rd_q     <= rd_q;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: driver tasks push expected responses, a
// negedge monitor pops and compares result, tag, latency and DONE stability.
module tb_muldiv_unit;
   localparam int EW = 77;   // {t0[31:0], lat[7:0], rd[4:0], result[31:0]}

   logic       SYS_clk;
   logic       SYS_reset_n;
   logic       flush;
   logic       busy;
   logic [1:0] dbg_state;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32), .MUL_BITS(4)) dut (
      .SYS_clk     (SYS_clk),
      .SYS_reset_n (SYS_reset_n),
      .flush       (flush),
      .bus         (bus),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial begin
      SYS_clk = 1'b0;
      forever #5 SYS_clk = ~SYS_clk;
   end

   int cyc = 0;
   always @(posedge SYS_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];
   int last_t0 = 0;
   int last_hs = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // driver: call at posedge+#1
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat,
                        input bit exp_rsp);
      int n;
      n = 0;
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_rs1    = a;
      bus.req_rs2    = b;
      bus.req_rd     = rd;
      @(negedge SYS_clk);
      while (!bus.req_ready && n < 200) begin
         @(negedge SYS_clk);
         n++;
      end
      if (!bus.req_ready) begin
         chk("accept_timeout", 64'(0), 64'(1));
         bus.req_valid = 1'b0;
      end else begin
         last_t0 = cyc + 1;
         if (exp_rsp) exp_q.push_back({32'(cyc + 1), 8'(lat), rd, res});
         @(posedge SYS_clk);
         #1;
         bus.req_valid  = 1'b0;
         bus.req_funct3 = 3'($urandom_range(0, 7));
         bus.req_rs1    = $urandom;
         bus.req_rs2    = $urandom;
         bus.req_rd     = 5'($urandom_range(0, 31));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
         @(negedge SYS_clk);
         n++;
      end
      if (n >= 100) chk("drain_timeout", 64'(0), 64'(1));
      @(posedge SYS_clk);
      #1;
   endtask

   // scoreboard monitor
   logic [EW-1:0] e;
   logic [31:0]   hold_res;
   logic [4:0]    hold_rd;
   bit            prev_valid = 1'b0;
   bit            prev_hs    = 1'b0;
   bit            hs;

   always @(negedge SYS_clk) begin
      hs = 1'b0;
      if (!SYS_reset_n) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (prev_hs) begin
            chk("post_hs_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("post_hs_req_ready", 64'(bus.req_ready), 64'(1));
         end
         if (bus.rsp_valid) begin
            if (!prev_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 64'(1), 64'(0));
               end else begin
                  e = exp_q[0];
                  chk("latency", 64'(cyc - int'(e[76:45])), 64'(e[44:37]));
                  chk("result", 64'(bus.rsp_result), 64'(e[31:0]));
                  chk("rd", 64'(bus.rsp_rd), 64'(e[36:32]));
               end
               hold_res = bus.rsp_result;
               hold_rd  = bus.rsp_rd;
            end else begin
               chk("hold_result", 64'(bus.rsp_result), 64'(hold_res));
               chk("hold_rd", 64'(bus.rsp_rd), 64'(hold_rd));
            end
            chk("done_req_ready", 64'(bus.req_ready), 64'(0));
            if (bus.rsp_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               hs      = 1'b1;
               last_hs = cyc + 1;
            end
         end
         prev_valid = bus.rsp_valid;
         prev_hs    = hs;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      SYS_reset_n    = 1'b0;
      flush          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_rs1    = '0;
      bus.req_rs2    = '0;
      bus.req_rd     = '0;
      bus.rsp_ready  = 1'b1;
      repeat (2) @(negedge SYS_clk);
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("reset_rsp_result", 64'(bus.rsp_result), 64'(0));
      chk("reset_rsp_rd", 64'(bus.rsp_rd), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      SYS_reset_n = 1'b1;
      @(posedge SYS_clk);
      #1;
      chk("reset_req_ready", 64'(bus.req_ready), 64'(1));

      // multiply low
      issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 9, 1'b1);
      issue(3'b000, 32'h12345678, 32'h10, 5'd2, 32'h23456780, 9, 1'b1);
      drain();
      // multiply high variants
      issue(3'b001, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 9, 1'b1);
      issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 9, 1'b1);
      issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE, 9, 1'b1);
      issue(3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd6, 32'h3FFFFFFF, 9, 1'b1);
      issue(3'b011, 32'h12345678, 32'h10, 5'd7, 32'h00000001, 9, 1'b1);
      drain();
      // divide / remainder
      issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFD, 33, 1'b1);
      issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 33, 1'b1);
      issue(3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 33, 1'b1);
      issue(3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 33, 1'b1);
      issue(3'b100, 32'd7, 32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 33, 1'b1);
      issue(3'b110, 32'd7, 32'hFFFFFFFE, 5'd14, 32'd1, 33, 1'b1);
      issue(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'd0, 33, 1'b1);
      issue(3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h80000000, 33, 1'b1);
      drain();
      // special cases
      issue(3'b100, 32'd5, 32'd0, 5'd15, 32'hFFFFFFFF, 1, 1'b1);
      issue(3'b110, 32'd5, 32'd0, 5'd16, 32'd5, 1, 1'b1);
      issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1, 1'b1);
      issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0, 1, 1'b1);
      issue(3'b101, 32'd5, 32'd0, 5'd19, 32'hFFFFFFFF, 1, 1'b1);
      issue(3'b111, 32'd5, 32'd0, 5'd20, 32'd5, 1, 1'b1);
      drain();

      // backpressure in DONE, then the next request right after the handshake
      bus.rsp_ready = 1'b0;
      issue(3'b000, 32'd5, 32'd6, 5'd21, 32'd30, 9, 1'b1);
      fork
         begin
            int n;
            n = 0;
            while (!bus.rsp_valid && n < 50) begin
               @(negedge SYS_clk);
               n++;
            end
            repeat (5) @(negedge SYS_clk);
            @(posedge SYS_clk);
            #1;
            bus.rsp_ready = 1'b1;
         end
         issue(3'b101, 32'd100, 32'd7, 5'd22, 32'd14, 33, 1'b1);
      join
      chk("accept_after_hs", 64'(last_t0 - last_hs), 64'(1));
      drain();

      // flush in the 4th CALC cycle
      issue(3'b001, 32'h11111111, 32'h22222222, 5'd25, 32'd0, 0, 1'b0);
      repeat (3) @(posedge SYS_clk);
      #1;
      flush = 1'b1;
      #1;
      chk("flush_req_ready", 64'(bus.req_ready), 64'(0));
      @(posedge SYS_clk);
      #1;
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'(0));
      chk("flush_state", 64'(dbg_state), 64'(0));
      chk("flush_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      repeat (12) @(posedge SYS_clk);
      #1;

      // async reset pulse mid-divide
      issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd26, 32'd0, 0, 1'b0);
      repeat (10) @(posedge SYS_clk);
      #1;
      SYS_reset_n = 1'b0;
      #2;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_state", 64'(dbg_state), 64'(0));
      chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("arst_rsp_result", 64'(bus.rsp_result), 64'(0));
      chk("arst_rsp_rd", 64'(bus.rsp_rd), 64'(0));
      @(negedge SYS_clk);
      SYS_reset_n = 1'b1;
      @(posedge SYS_clk);
      #1;
      issue(3'b000, 32'd3, 32'd4, 5'd9, 32'd12, 9, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
